multicycle_control_fsm: RTL and testbench

Control sequencer for the multi-cycle RV32I datapath. It steps each instruction through fetch, decode, execute, memory and writeback states, driving the shared ALU, register file, IR/PC and unified instruction/data memory. A ready handshake stalls the sequence on slow memory. ALU control is decoded internally from op/funct3/funct7 with the same encoding the single-cycle core uses.

---
 rtl/multicycle_control_fsm.sv | 204 ++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: steps each instruction through
// fetch/decode/execute/memory/writeback and drives the shared datapath.
// Optional feature macro: ILLEGAL_OP_TRAP_EN (unsupported op traps until reset).
module multicycle_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               MemWrite,
  output logic               AdrSrc,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ImmSrc,
  output logic [2:0]         ALUControl,
  output logic               instr_done,
  output logic [STATE_W-1:0] state_o,
  output logic               illegal_instr
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  state_t     state, state_next;
  logic [1:0] alu_op;

  // Only funct7[5] distinguishes sub from add; other bits are don't-care here.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // State register; reset parks the sequencer in FETCH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= state_next;
  end

  // Next-state and per-state control outputs; everything is forced low while
  // reset is asserted so an aborted instruction cannot leave an enable high.
  always_comb begin
    state_next    = FETCH;
    mem_req       = 1'b0;
    MemWrite      = 1'b0;
    AdrSrc        = 1'b0;
    IRWrite       = 1'b0;
    PCWrite       = 1'b0;
    RegWrite      = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ImmSrc        = 2'b00;
    alu_op        = 2'b00;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;
    case (state)
      FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          state_next = DECODE;
        end else begin
          state_next = FETCH;
        end
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b10;
        case (op)
          7'b0000011, 7'b0100011: state_next = MEMADR;
          7'b0110011:             state_next = EXECUTER;
          7'b0010011:             state_next = EXECUTEI;
          7'b1100011:             state_next = BEQ;
          7'b1101111:             state_next = JAL;
`ifdef ILLEGAL_OP_TRAP_EN
          default:                state_next = TRAP;
`else
          default:                state_next = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        // op[5] separates sw (0100011) from lw (0000011)
        ImmSrc     = op[5] ? 2'b01 : 2'b00;
        state_next = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req    = 1'b1;
        AdrSrc     = 1'b1;
        state_next = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      MEMWRITE: begin
        mem_req    = 1'b1;
        MemWrite   = 1'b1;
        AdrSrc     = 1'b1;
        instr_done = mem_ready;
        state_next = mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        ALUSrcA    = 2'b10;
        alu_op     = 2'b10;
        state_next = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        alu_op     = 2'b10;
        state_next = ALUWB;
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      BEQ: begin
        ALUSrcA    = 2'b10;
        alu_op     = 2'b01;
        PCWrite    = zero;
        instr_done = 1'b1;
      end
      JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        ImmSrc     = 2'b11;
        PCWrite    = 1'b1;
        state_next = ALUWB;
      end
      TRAP: begin
`ifdef ILLEGAL_OP_TRAP_EN
        illegal_instr = 1'b1;
        state_next    = TRAP;
`else
        state_next    = FETCH;
`endif
      end
      default: state_next = FETCH;
    endcase
    if (!rst) begin
      mem_req       = 1'b0;
      MemWrite      = 1'b0;
      AdrSrc        = 1'b0;
      IRWrite       = 1'b0;
      PCWrite       = 1'b0;
      RegWrite      = 1'b0;
      ResultSrc     = 2'b00;
      ALUSrcA       = 2'b00;
      ALUSrcB       = 2'b00;
      ImmSrc        = 2'b00;
      alu_op        = 2'b00;
      instr_done    = 1'b0;
      illegal_instr = 1'b0;
    end
  end

  // ALU control decode, same encoding as the single-cycle core.
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = ({op[5], funct7[5]} == 2'b11) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  assign state_o = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: stimulus pushes per-cycle
// expected control vectors; a monitor pops and compares on every falling edge.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic       instr_done;
  logic [3:0] state_o;
  logic       illegal_instr;

  multicycle_control_fsm #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .instr_done(instr_done), .state_o(state_o),
    .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [22:0] v;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  bit   stim_done  = 1'b0;

  // vector layout: state, mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
  // ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, instr_done, illegal_instr
  task automatic step(input string nm, input logic [3:0] st,
                      input bit mr, input bit mw, input bit as, input bit irw,
                      input bit pcw, input bit rw,
                      input logic [1:0] rs, input logic [1:0] sa,
                      input logic [1:0] sb, input logic [1:0] is,
                      input logic [2:0] alu, input bit done, input bit ill);
    exp_t e;
    e.v    = {st, mr, mw, as, irw, pcw, rw, rs, sa, sb, is, alu, done, ill};
    e.name = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic zero_cyc(input string nm);
    step(nm, 4'd0, 0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0, 0);
  endtask
  task automatic fetch_go(input string nm);
    mem_ready = 1'b1;
    step(nm, 4'd0, 1,0,0,1,1,0, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0, 0);
  endtask
  task automatic fetch_stall(input string nm);
    mem_ready = 1'b0;
    step(nm, 4'd0, 1,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0, 0);
    mem_ready = 1'b1;
  endtask
  task automatic decode(input string nm);
    step(nm, 4'd1, 0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b10, 3'b000, 0, 0);
  endtask
  task automatic aluwb(input string nm);
    step(nm, 4'd8, 0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b000, 1, 0);
  endtask
  task automatic rtype(input string nm, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [2:0] alu);
    op = 7'b0110011; funct3 = f3; funct7 = f7;
    fetch_go({nm, "_fetch"});
    decode({nm, "_decode"});
    step({nm, "_exer"}, 4'd6, 0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b00, alu, 0, 0);
    aluwb({nm, "_aluwb"});
  endtask
  task automatic itype(input string nm, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [2:0] alu);
    op = 7'b0010011; funct3 = f3; funct7 = f7;
    fetch_go({nm, "_fetch"});
    decode({nm, "_decode"});
    step({nm, "_exei"}, 4'd7, 0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00, alu, 0, 0);
    aluwb({nm, "_aluwb"});
  endtask
  task automatic beq(input string nm, input bit z);
    op = 7'b1100011; funct3 = 3'b000; funct7 = 7'b0000000; zero = z;
    fetch_go({nm, "_fetch"});
    decode({nm, "_decode"});
    step({nm, "_beq"}, 4'd9, 0,0,0,0,z,0, 2'b00,2'b10,2'b00,2'b00, 3'b001, 1, 0);
    zero = 1'b0;
  endtask

  // Monitor: one comparison per falling edge while expectations are pending.
  initial begin
    exp_t  e;
    logic [22:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {state_o, mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, instr_done,
               illegal_instr};
        compared++;
        if (act !== e.v) begin
          mismatched++;
          $display("FAIL %s: got %b required %b", e.name, act, e.v);
        end
      end
    end
  end

  // Stimulus
  initial begin
    rst = 1'b0; op = '0; funct3 = '0; funct7 = '0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    zero_cyc("reset0");
    zero_cyc("reset1");
    zero_cyc("reset2");
    rst = 1'b1;

    rtype("sub", 3'b000, 7'b0100000, 3'b001);
    rtype("and", 3'b111, 7'b0000000, 3'b010);
    itype("addi_f7hi", 3'b000, 7'b0100000, 3'b000);
    itype("slti", 3'b010, 7'b0000000, 3'b101);
    itype("ori", 3'b110, 7'b0000000, 3'b011);

    // lw with one fetch stall and two memory wait cycles
    op = 7'b0000011; funct3 = 3'b010; funct7 = '0;
    fetch_stall("lw_fstall");
    fetch_go("lw_fetch");
    decode("lw_decode");
    step("lw_memadr", 4'd2, 0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 3'b000, 0, 0);
    mem_ready = 1'b0;
    step("lw_rd_w0", 4'd3, 1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0, 0);
    step("lw_rd_w1", 4'd3, 1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0, 0);
    mem_ready = 1'b1;
    step("lw_rd_ok", 4'd3, 1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0, 0);
    step("lw_memwb", 4'd4, 0,0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00, 3'b000, 1, 0);

    // sw with one write wait cycle
    op = 7'b0100011;
    fetch_go("sw_fetch");
    decode("sw_decode");
    step("sw_memadr", 4'd2, 0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b01, 3'b000, 0, 0);
    mem_ready = 1'b0;
    step("sw_wr_w0", 4'd5, 1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0, 0);
    mem_ready = 1'b1;
    step("sw_wr_ok", 4'd5, 1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 1, 0);

    beq("beq_taken", 1'b1);
    beq("beq_not", 1'b0);

    op = 7'b1101111; funct3 = 3'b000;
    fetch_go("jal_fetch");
    decode("jal_decode");
    step("jal_jal", 4'd10, 0,0,0,0,1,0, 2'b00,2'b01,2'b10,2'b11, 3'b000, 0, 0);
    aluwb("jal_aluwb");

    op = 7'b1111111;
    fetch_go("ill_fetch");
    decode("ill_decode");
`ifdef ILLEGAL_OP_TRAP_EN
    for (int i = 0; i < 10; i++)
      step("ill_trap", 4'd11, 0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0, 1);
    rst = 1'b0;
    zero_cyc("ill_reset");
    rst = 1'b1;
`endif
    rtype("add_after_ill", 3'b000, 7'b0000000, 3'b000);

    // reset asserted while lw waits on memory
    op = 7'b0000011; funct3 = 3'b010;
    fetch_go("abort_fetch");
    decode("abort_decode");
    step("abort_memadr", 4'd2, 0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 3'b000, 0, 0);
    mem_ready = 1'b0;
    step("abort_rd_w", 4'd3, 1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0, 0);
    mem_ready = 1'b1;
    rst = 1'b0;
    zero_cyc("abort_rst0");
    zero_cyc("abort_rst1");
    rst = 1'b1;
    rtype("sub_recover", 3'b000, 7'b0100000, 3'b001);
    stim_done = 1'b1;
  end

  // Drain the scoreboard and report; bounded so the run always terminates.
  initial begin
    int budget;
    wait (stim_done);
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish required finish before 20000");
    $fatal(1, "timeout");
  end

endmodule
